// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES-128 decryption round controller: one inverse round per cycle,
// with round keys fetched by index from an external expanded-key store.
module aes_dec_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] cipher_in,
    input  logic         key_valid,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plain_out,
    output logic         busy,
    output logic         abort
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    localparam logic [3:0] RK_LAST  = 4'(NR);
    localparam logic [3:0] RND_INIT = 4'(NR - 1);

    state_t         state, state_nxt;
    logic [3:0]     rnd;
    logic [127:0]   st;
    logic           abort_q;
    logic           accept;
    logic           key_lost;
    logic [127:0]   isb;
    logic [127:0]   round_out;
    logic [127:0]   final_out;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] res;
        logic [7:0] sq;
        res = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            res = gmul(res, sq);
        end
        return res;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Inverse affine map followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        int           src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = r + 4 * ((c - r + 4) % 4);
                o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * src -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119 - 32 * c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111 - 32 * c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103 - 32 * c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    assign accept    = (state == IDLE) && in_valid && key_valid;
    assign key_lost  = ((state == ROUND) || (state == FINAL)) && !key_valid;
    assign isb       = inv_sub_bytes(inv_shift_rows(st));
    assign final_out = isb ^ rk_in;
    assign round_out = inv_mix_columns(final_out);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = ROUND;
            ROUND: begin
                if (!key_valid)      state_nxt = IDLE;
                else if (rnd == 4'd1) state_nxt = FINAL;
            end
            FINAL: state_nxt = key_valid ? DONE : IDLE;
            DONE:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= '0;
            rnd     <= 4'd0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= key_lost;
            case (state)
                IDLE: begin
                    if (accept) begin
                        st  <= cipher_in ^ rk_in;
                        rnd <= RND_INIT;
                    end
                end
                ROUND: begin
                    if (!key_valid) begin
                        st  <= '0;
                        rnd <= 4'd0;
                    end else begin
                        st <= round_out;
                        // rnd parks at 1 while FINAL runs instead of wrapping.
                        if (rnd > 4'd1) rnd <= rnd - 4'd1;
                    end
                end
                FINAL: begin
                    st  <= key_valid ? final_out : '0;
                    rnd <= 4'd0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == ROUND) || (state == FINAL);
        out_valid = (state == DONE);
        abort     = abort_q;
        plain_out = (state == DONE) ? st : '0;
        case (state)
            IDLE:    rk_idx = RK_LAST;
            ROUND:   rk_idx = rnd;
            default: rk_idx = 4'd0;
        endcase
    end

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Directed bench for aes_dec_round_ctrl using the FIPS-197 C.1 AES-128 vector
// and a combinational round-key store model.
module tb_aes_dec_round_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] cipher_in;
    logic         key_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plain_out;
    logic         busy;
    logic         abort;

    logic [127:0] rk_tab [0:15];
    int           n_tests = 0;
    int           n_fail  = 0;

    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

    aes_dec_round_ctrl #(.NR(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .cipher_in(cipher_in), .key_valid(key_valid), .rk_idx(rk_idx),
        .rk_in(rk_in), .out_valid(out_valid), .out_ready(out_ready),
        .plain_out(plain_out), .busy(busy), .abort(abort)
    );

    always #5 clk = ~clk;

    assign rk_in = rk_tab[rk_idx];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"},  128'(in_ready),  128'd1);
        check({tag, " out_valid"}, 128'(out_valid), 128'd0);
        check({tag, " busy"},      128'(busy),      128'd0);
        check({tag, " abort"},     128'(abort),     128'd0);
        check({tag, " rk_idx"},    128'(rk_idx),    128'd10);
        check({tag, " plain_out"}, plain_out,       128'd0);
    endtask

    // Accepts CT from IDLE and walks to the first DONE cycle, checking the
    // key index on every cycle and the result on cycle 11.
    task automatic run_c1(input string tag);
        in_valid  = 1'b1;
        cipher_in = CT;
        check({tag, " accept in_ready"}, 128'(in_ready), 128'd1);
        check({tag, " accept rk_idx"},   128'(rk_idx),   128'd10);
        tick();
        in_valid  = 1'b0;
        cipher_in = '1;
        for (int n = 1; n <= 10; n++) begin
            check($sformatf("%s rk_idx c%0d", tag, n), 128'(rk_idx), 128'(10 - n));
            check($sformatf("%s busy c%0d", tag, n),   128'(busy),   128'd1);
            check($sformatf("%s out_valid c%0d", tag, n), 128'(out_valid), 128'd0);
            tick();
        end
        check({tag, " out_valid c11"}, 128'(out_valid), 128'd1);
        check({tag, " plain_out c11"}, plain_out, PT);
    endtask

    initial begin
        int first_out;
        int second_acc;
        int seen_out;
        bit done2;

        rk_tab[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk_tab[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        rk_tab[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        rk_tab[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        rk_tab[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        rk_tab[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        rk_tab[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        rk_tab[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        rk_tab[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        rk_tab[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        rk_tab[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        for (int i = 11; i < 16; i++) rk_tab[i] = '0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        cipher_in = '0;
        key_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // No accept while the key store is not ready.
        key_valid = 1'b0;
        in_valid  = 1'b1;
        cipher_in = CT;
        tick();
        tick();
        check("nokey busy",     128'(busy),     128'd0);
        check("nokey in_ready", 128'(in_ready), 128'd1);
        check("nokey rk_idx",   128'(rk_idx),   128'd10);
        in_valid  = 1'b0;
        key_valid = 1'b1;
        tick();

        // C.1 with backpressure held for 5 cycles in DONE.
        out_ready = 1'b0;
        run_c1("c1");
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("hold out_valid %0d", k), 128'(out_valid), 128'd1);
            check($sformatf("hold plain_out %0d", k), plain_out, PT);
        end
        // in_valid offered in DONE with out_ready must not start a new operation.
        in_valid  = 1'b1;
        cipher_in = CT;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("release in_ready",  128'(in_ready),  128'd1);
        check("release busy",      128'(busy),      128'd0);
        check("release out_valid", 128'(out_valid), 128'd0);
        check("release plain_out", plain_out,       128'd0);
        tick();
        check("no accept in DONE busy", 128'(busy), 128'd0);

        // Abort: key store invalidated during cycle 4.
        in_valid  = 1'b1;
        cipher_in = CT;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        key_valid = 1'b0;
        check("abort c4 busy",  128'(busy),  128'd1);
        check("abort c4 abort", 128'(abort), 128'd0);
        tick();
        key_valid = 1'b1;
        check("abort pulse",     128'(abort),     128'd1);
        check("abort in_ready",  128'(in_ready),  128'd1);
        check("abort busy",      128'(busy),      128'd0);
        check("abort out_valid", 128'(out_valid), 128'd0);
        tick();
        check("abort pulse end", 128'(abort), 128'd0);
        seen_out = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid) seen_out++;
        end
        check("abort no output", 128'(seen_out), 128'd0);

        // Reset during cycle 6, then a clean C.1 run.
        in_valid  = 1'b1;
        cipher_in = CT;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("pre-reset busy", 128'(busy), 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        run_c1("post-rst");
        out_ready = 1'b1;
        tick();

        // Back-to-back with in_valid held high; current cycle is the first accept.
        in_valid   = 1'b1;
        cipher_in  = CT;
        first_out  = -1;
        second_acc = -1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (out_valid && first_out < 0) begin
                first_out = t;
                check("b2b first plain_out", plain_out, PT);
            end
            if (in_ready) begin
                second_acc = t;
                break;
            end
        end
        check("b2b first out cycle", 128'(first_out), 128'd11);
        // Cycles spanned from first accept cycle through second accept cycle.
        check("b2b accept span", 128'(second_acc + 1), 128'd13);
        done2 = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            in_valid = 1'b0;
            if (out_valid) begin
                done2 = 1'b1;
                check("b2b second plain_out", plain_out, PT);
                break;
            end
        end
        check("b2b second done", 128'(done2), 128'd1);
        tick();
        check("b2b idle in_ready", 128'(in_ready), 128'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_dec_round_ctrl.md
AES_DEC_ROUND_CTRL -- requirements
Module: aes_dec_round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES rounds; only 10 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  ciphertext offered.
REQ-005 SHALL have port in_ready  output  1  controller accepts ciphertext this cycle.
REQ-006 SHALL have port cipher_in  input  128  ciphertext; byte 0 at [127:120], column-major state order.
REQ-007 SHALL have port key_valid  input  1  external round-key store holds a complete expanded key.
REQ-008 SHALL have port rk_idx  output  4  round-key index requested from the key store (0..10).
REQ-009 SHALL have port rk_in  input  128  round key for rk_idx; combinational same-cycle response.
REQ-010 SHALL have port out_valid  output  1  plaintext available.
REQ-011 SHALL have port out_ready  input  1  consumer takes plaintext.
REQ-012 SHALL have port plain_out  output  128  plaintext, same byte order as cipher_in.
REQ-013 SHALL have port busy  output  1  high in ROUND or FINAL.
REQ-014 SHALL have port abort  output  1  one-cycle pulse when an operation is discarded.

Function
REQ-015 SHALL implement FSM states IDLE, ROUND, FINAL and DONE, with a 4-bit round counter rnd and a 128-bit state register st.
REQ-016 SHALL drive in_ready=1 only in IDLE; accept on in_valid && in_ready && key_valid.
REQ-017 SHALL drive rk_idx: IDLE=10; ROUND=rnd; FINAL=0; DONE=0.
REQ-018 SHALL, on accept: st <= cipher_in ^ rk_in (key 10), rnd <= 9, go to ROUND.
REQ-019 SHALL, in ROUND: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk_in); rnd <= rnd-1; when rnd==1, go to FINAL.
REQ-020 SHALL, in FINAL: st <= InvSubBytes(InvShiftRows(st)) ^ rk_in (key 0), go to DONE.
REQ-021 SHALL assert out_valid only in DONE; plain_out=st while out_valid, else 0.
REQ-022 SHALL, in DONE with out_ready=1: go to IDLE next cycle; with out_ready=0: hold st and out_valid.
REQ-023 SHALL have a fixed latency of 11 cycles from the accept edge to the first out_valid=1 cycle, independent of out_ready.
REQ-024 SHALL accept no new input in DONE, even when out_ready=1 in the same cycle; the next accept is possible the cycle after returning to IDLE.
REQ-025 SHALL ignore in_valid while key_valid=0 in IDLE; in_ready remains 1.
REQ-026 SHALL, on key_valid=0 in ROUND or FINAL: discard st, pulse abort for 1 cycle, and go to IDLE next cycle with no out_valid.
REQ-027 SHALL not check key_valid in DONE; the computed result remains deliverable.
REQ-028 SHALL hold in_valid/cipher_in changes while not in IDLE without effect.
REQ-029 SHALL implement the inverse transforms combinationally inside the block (InvShiftRows byte mapping b[i]=s[(i*13) mod 16 order per FIPS-197], InvSubBytes, InvMixColumns over GF(2^8) with polynomial 0x11B).
REQ-030 SHALL use only X-free outputs; the rnd decrement never wraps below 1 in ROUND.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, take priority over all other events, including mid-operation.
REQ-032 SHALL, after reset: state=IDLE, rnd=0, st=0, in_ready=1, out_valid=0, busy=0, abort=0, rk_idx=10, plain_out=0.

Verification
REQ-033 SHALL pass FIPS-197 C.1 (key 000102..0f expanded in store): cipher_in=69c4e0d86a7b0430d8cdb78070b4c55a -> out_valid on cycle 11, plain_out=00112233445566778899aabbccddeeff.
REQ-034 SHALL check rk_idx sequence: after accept, rk_idx=9,8,...,1,0 on cycles 1-10, and 10 on the accept cycle.
REQ-035 SHALL check backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and plain_out stable; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-036 SHALL check abort: key_valid dropped at cycle 4 after accept -> abort=1 for one cycle, IDLE, no out_valid.
REQ-037 SHALL check reset mid-operation: rst at cycle 6 -> all outputs at reset values next cycle; a following C.1 vector completes correctly.
REQ-038 SHALL check back-to-back: two vectors, in_valid held high, out_ready=1 -> second accept 13 cycles after the first, both results correct.
